// File: rtl/uart_rx.sv
// UART receiver with a 2-flop input synchronizer and an oversampled frame FSM.
// The start bit is qualified at its mid-point; data and stop bits are then
// sampled every OVERSAMPLE ticks, i.e. near the centre of each bit.
// A low stop bit reports a framing error and disarms the receiver, so a held-low
// line (break) cannot start a new frame until the line has been seen high again.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick_os,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Tick value that marks the middle of the start bit, counted from the falling edge.
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  // Tick value that marks one full bit period after the previous sample point.
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 rxs;
  state_t               state_q;
  logic                 armed_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 rx_frame_err_q;

  // Bring the asynchronous line into the clk domain; reset to the idle (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // Frame FSM: start detection, bit-centre sampling, stop check and result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      armed_q        <= 1'b1;
      tick_q         <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A falling edge is acted on immediately; the tick only paces later sampling.
          if (rxs) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= S_START;
            tick_q  <= '0;
            armed_q <= 1'b0;
          end
        end

        S_START: begin
          if (baud_tick_os) begin
            if (tick_q == TICK_MID) begin
              tick_q <= '0;
              if (!rxs) begin
                state_q <= S_DATA;
                bit_q   <= '0;
              end else begin
                // Line went back high before mid-bit: treat as a glitch, report nothing.
                state_q <= S_IDLE;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (baud_tick_os) begin
            if (tick_q == TICK_END) begin
              tick_q <= '0;
              for (int i = 0; i < DATA_BITS; i++) begin
                if (bit_q == BW'(i)) begin
                  shift_q[i] <= rxs;
                end
              end
              if (bit_q == BIT_LAST) begin
                state_q <= S_STOP;
                bit_q   <= '0;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        S_STOP: begin
          if (baud_tick_os) begin
            if (tick_q == TICK_END) begin
              tick_q  <= '0;
              state_q <= S_IDLE;
              if (rxs) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                // Keep the last good word; stay disarmed until the line returns high.
                rx_frame_err_q <= 1'b1;
                armed_q        <= 1'b0;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          tick_q  <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table of frames at several bit rates plus hand-written
// sequences for glitch rejection, break handling, back-to-back frames,
// mid-frame reset and a 1-bit-wide instance.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick_os = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx1_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;
  logic [0:0] rx1_data;
  logic       rx1_valid, rx1_frame_err, rx1_busy;

  int n_vec = 0;
  int n_err = 0;
  int vcnt = 0, ecnt = 0, bcnt = 0, v1cnt = 0, e1cnt = 0, both_cnt = 0;
  logic [7:0] vlog [0:63];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         bclk;
    int         exp_v;
    int         exp_e;
    logic [7:0] exp_d;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) u_dut (
    .clk(clk), .rst(rst), .baud_tick_os(baud_tick_os), .rx_serial(rx_serial),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  uart_rx #(.DATA_BITS(1), .OVERSAMPLE(16)) u_dut1 (
    .clk(clk), .rst(rst), .baud_tick_os(baud_tick_os), .rx_serial(rx1_serial),
    .rx_data(rx1_data), .rx_valid(rx1_valid), .rx_frame_err(rx1_frame_err), .rx_busy(rx1_busy)
  );

  // Oversample tick: one clk out of every four.
  initial begin : tickgen
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      t++;
      baud_tick_os = ((t % 4) == 0);
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (vcnt < 64) vlog[vcnt] = rx_data;
      vcnt++;
    end
    if (rx_frame_err) ecnt++;
    if (rx_valid && rx_frame_err) both_cnt++;
    if (rx_busy) bcnt++;
    if (rx1_valid) v1cnt++;
    if (rx1_frame_err) e1cnt++;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int bclk);
    rx_serial = b;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
    drive_bit(stop, bclk);
  endtask

  task automatic send1(input logic b);
    rx1_serial = 1'b0;
    repeat (64) @(negedge clk);
    rx1_serial = b;
    repeat (64) @(negedge clk);
    rx1_serial = 1'b1;
    repeat (64 + 192) @(negedge clk);
  endtask

  initial begin : main
    int v0, e0, b0, v10, e10, dl;
    logic [7:0] d0;
    int rates [3];
    rates = '{64, 62, 66};

    tbl[0] = '{8'hA5, 1'b1, 64, 1, 0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 64, 0, 1, 8'hA5};
    tbl[2] = '{8'h5A, 1'b1, 64, 1, 0, 8'h5A};
    tbl[3] = '{8'h00, 1'b1, 62, 1, 0, 8'h00};
    tbl[4] = '{8'hFF, 1'b1, 66, 1, 0, 8'hFF};
    tbl[5] = '{8'h81, 1'b1, 62, 1, 0, 8'h81};
    tbl[6] = '{8'h7E, 1'b0, 66, 0, 1, 8'h81};

    // Reset state
    repeat (10) @(negedge clk);
    check("reset rx_data", rx_data, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_frame_err", rx_frame_err, 0);
    check("reset rx_busy", rx_busy, 0);
    check("reset rx1_data", rx1_data, 0);
    rst = 1'b0;
    idle(200);

    // Table of single frames
    for (int k = 0; k < 7; k++) begin
      v0 = vcnt;
      e0 = ecnt;
      send_frame(tbl[k].d, tbl[k].stop, tbl[k].bclk);
      idle(192);
      check($sformatf("vec%0d valid pulses", k), vcnt - v0, tbl[k].exp_v);
      check($sformatf("vec%0d frame_err pulses", k), ecnt - e0, tbl[k].exp_e);
      check($sformatf("vec%0d rx_data", k), rx_data, tbl[k].exp_d);
      check($sformatf("vec%0d busy after", k), rx_busy, 0);
    end

    // Glitch: 3 ticks low on an idle line
    v0 = vcnt; e0 = ecnt; b0 = bcnt; d0 = rx_data;
    rx_serial = 1'b0;
    repeat (12) @(negedge clk);
    idle(128);
    dl = bcnt - b0;
    check("glitch valid pulses", vcnt - v0, 0);
    check("glitch frame_err pulses", ecnt - e0, 0);
    check("glitch rx_data held", rx_data, d0);
    check("glitch busy window 20..48 clk", (dl >= 20 && dl <= 48), 1);
    check("glitch busy after", rx_busy, 0);

    // Break: bad stop bit, then line held low for 40 bit times
    v0 = vcnt; e0 = ecnt; d0 = rx_data;
    send_frame(8'h3C, 1'b0, 64);
    check("break frame_err pulses", ecnt - e0, 1);
    check("break rx_data held", rx_data, d0);
    v0 = vcnt; e0 = ecnt; b0 = bcnt;
    rx_serial = 1'b0;
    repeat (40 * 64) @(negedge clk);
    check("break hold busy cycles", bcnt - b0, 0);
    check("break hold valid pulses", vcnt - v0, 0);
    check("break hold frame_err pulses", ecnt - e0, 0);
    idle(192);
    v0 = vcnt;
    send_frame(8'h5A, 1'b1, 64);
    idle(192);
    check("after break valid pulses", vcnt - v0, 1);
    check("after break rx_data", rx_data, 8'h5A);

    // Back-to-back frames at nominal, fast and slow bit rates
    for (int r = 0; r < 3; r++) begin
      v0 = vcnt; e0 = ecnt;
      send_frame(8'h00, 1'b1, rates[r]);
      send_frame(8'hFF, 1'b1, rates[r]);
      send_frame(8'h81, 1'b1, rates[r]);
      idle(192);
      check($sformatf("b2b %0d valid pulses", rates[r]), vcnt - v0, 3);
      check($sformatf("b2b %0d frame_err", rates[r]), ecnt - e0, 0);
      check($sformatf("b2b %0d word0", rates[r]), vlog[v0], 8'h00);
      check($sformatf("b2b %0d word1", rates[r]), vlog[v0 + 1], 8'hFF);
      check($sformatf("b2b %0d word2", rates[r]), vlog[v0 + 2], 8'h81);
    end

    // Reset during bit 4 of frame 0xF0
    v0 = vcnt; e0 = ecnt;
    for (int i = 0; i < 5; i++) drive_bit(1'b0, 64);
    rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    check("pre-reset busy", rx_busy, 1);
    rst = 1'b1;
    #1;
    check("midreset rx_data", rx_data, 0);
    check("midreset rx_busy", rx_busy, 0);
    check("midreset rx_valid", rx_valid, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (39) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(1'b1, 64);
    drive_bit(1'b1, 64);
    idle(192);
    check("midreset valid pulses", vcnt - v0, 0);
    check("midreset frame_err pulses", ecnt - e0, 0);
    check("midreset busy after", rx_busy, 0);
    v0 = vcnt;
    send_frame(8'h11, 1'b1, 64);
    idle(192);
    check("post-reset valid pulses", vcnt - v0, 1);
    check("post-reset rx_data", rx_data, 8'h11);

    check("valid/frame_err overlap cycles", both_cnt, 0);

    // Single data bit instance
    v10 = v1cnt; e10 = e1cnt;
    send1(1'b1);
    check("db1 bit1 valid pulses", v1cnt - v10, 1);
    check("db1 bit1 rx_data", rx1_data, 1);
    check("db1 bit1 frame_err", e1cnt - e10, 0);
    v10 = v1cnt;
    send1(1'b0);
    check("db1 bit0 valid pulses", v1cnt - v10, 1);
    check("db1 bit0 rx_data", rx1_data, 0);
    check("db1 busy after", rx1_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
